// File: rtl/dmg_bus_responder_pkg.sv
// Shared types and constants for the DMG bus responder.
// Holds the responder FSM encoding and the precharged open-bus value.
package dmg_bus_responder_pkg;

    localparam int DATA_W = 8;

    // An undriven data bus reads back as all ones.
    localparam logic [DATA_W-1:0] OPEN_BUS_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/dmg_resp_ram.sv
// Byte array backing the responder window: synchronous write, registered read.
// The storage has no reset, so contents survive a responder reset.
module dmg_resp_ram
    import dmg_bus_responder_pkg::*;
#(
    parameter int DEPTH = 127,
    parameter int IDX_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmg_bus_responder.sv
// Address-bus responder: serves a window of addresses from a byte array,
// answers open-bus elsewhere, and completes each access after a wait-state count.
module dmg_bus_responder
    import dmg_bus_responder_pkg::*;
#(
    parameter logic [15:0]       ADDR_BASE   = 16'hFF80,
    parameter logic [15:0]       ADDR_LAST   = 16'hFFFE,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] OPEN_BUS    = OPEN_BUS_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRES,
    input  logic [15:0]       A,
    input  logic              RD,
    input  logic              WR,
    input  logic [DATA_W-1:0] Din,
    output logic [DATA_W-1:0] Dout,
    output logic              READY,
    output logic              HIT,
    output logic              COLL
);

    localparam int DEPTH = int'(ADDR_LAST) - int'(ADDR_BASE) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_state_e       state_reg;
    resp_state_e       state_next;
    logic [3:0]        cnt_reg;
    logic [15:0]       addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              write_reg;
    logic              ready_reg;
    logic              hit_reg;
    logic              from_ram_reg;
    logic              coll_reg;

    logic              req;
    logic              accept;
    logic              complete;
    logic              in_window;
    logic              ram_we;
    logic              ram_re;
    logic              coll_event;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_rdata;

    assign req = RD | WR;

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            state_reg <= RESP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RESP_IDLE, RESP_RESP: begin
                if (accept) begin
                    state_next = (WAIT_CYCLES > 0) ? RESP_WAIT : RESP_RESP;
                end else begin
                    state_next = RESP_IDLE;
                end
            end
            RESP_WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP_RESP;
                end
            end
            default: state_next = RESP_IDLE;
        endcase
    end

    // RESP is the array-access cycle; the registered outputs present its
    // result (READY, HIT, Dout) in the following cycle.
    always_comb begin
        accept     = 1'b0;
        complete   = 1'b0;
        coll_event = 1'b0;
        in_window  = (addr_reg >= ADDR_BASE) && (addr_reg <= ADDR_LAST);
        ram_idx    = IDX_W'(addr_reg - ADDR_BASE);
        unique case (state_reg)
            RESP_IDLE: begin
                accept     = req;
                coll_event = RD & WR;
            end
            RESP_WAIT: begin
                coll_event = req;
            end
            RESP_RESP: begin
                accept     = req;
                complete   = 1'b1;
                coll_event = RD & WR;
            end
            default: ;
        endcase
        ram_we = nRES && complete && write_reg && in_window;
        ram_re = nRES && complete && !write_reg && in_window;
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            cnt_reg      <= 4'd0;
            addr_reg     <= 16'd0;
            data_reg     <= '0;
            write_reg    <= 1'b0;
            ready_reg    <= 1'b0;
            hit_reg      <= 1'b0;
            from_ram_reg <= 1'b0;
            coll_reg     <= 1'b0;
        end else begin
            ready_reg <= complete;
            hit_reg   <= complete && in_window;
            if (complete && !write_reg) begin
                from_ram_reg <= in_window;
            end
            if (accept) begin
                addr_reg  <= A;
                data_reg  <= Din;
                write_reg <= WR;
                cnt_reg   <= 4'(WAIT_CYCLES);
            end else if (state_reg == RESP_WAIT) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (coll_event) begin
                coll_reg <= 1'b1;
            end
        end
    end

    dmg_resp_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_idx),
        .wdata (data_reg),
        .rdata (ram_rdata)
    );

    // The RAM read register holds the last in-window read; an out-of-window
    // read or reset switches the output back to the open-bus value.
    assign Dout  = from_ram_reg ? ram_rdata : OPEN_BUS;
    assign READY = ready_reg;
    assign HIT   = hit_reg;
    assign COLL  = coll_reg;

endmodule
